divider_11: RTL and testbench
=============================

Name: divider_11

Overview:
- Iterative radix-2 restoring divider; the inverse of the 11x11 mantissa multiplier.
- Divides a 22-bit dividend by an 11-bit divisor and returns an 11-bit quotient and an 11-bit remainder.
- Used by the FP divide datapath for mantissa division: dividend = mantissa_a << 11, divisor = mantissa_b.
- Valid/ready on both sides; one operation in flight at a time.

Parameters:
- WIDTH, 11: divisor, quotient and remainder width. Dividend is 2*WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  2*WIDTH  numerator.
- divisor  in  WIDTH  denominator.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  WIDTH  floor(dividend/divisor).
- remainder  out  WIDTH  dividend mod divisor.
- div_by_zero  out  1  divisor was 0.
- overflow  out  1  quotient does not fit in WIDTH bits.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low (rst_n).
- Reset values:
  - State = IDLE.
  - out_valid = 0; quotient, remainder, div_by_zero, overflow = 0.
  - in_ready = 1 once reset is released.
- in_ready is high only in IDLE. An operation is accepted on a clk edge where in_valid && in_ready; operands are captured into internal registers.
- State IDLE:
  - On accept with divisor == 0: go to DONE. Set div_by_zero = 1, quotient = all ones, remainder = dividend[WIDTH-1:0].
  - Else on accept with dividend[2*WIDTH-1:WIDTH] >= divisor: go to DONE. Set overflow = 1, quotient = all ones, remainder = 0.
  - Else on accept: go to BUSY. Load partial remainder = {1'b0, dividend[2*WIDTH-1:WIDTH]}, load step counter = WIDTH-1.
- State BUSY, one quotient bit per cycle, MSB first:
  - trial = {partial remainder, next dividend bit} - {1'b0, divisor}, computed WIDTH+1 bits wide.
  - trial non-negative: quotient bit = 1, partial remainder = trial.
  - trial negative: quotient bit = 0, shifted value kept.
  - After the step where the counter equals 0: go to DONE with quotient and remainder final and both flags cleared.
- State DONE:
  - out_valid = 1.
  - Outputs are held stable while out_ready = 0.
  - On out_valid && out_ready: go to IDLE, out_valid = 0.
  - The next input is accepted no earlier than the cycle after the handshake; in_ready is low in DONE.
- Latency, accept edge to out_valid high:
  - Normal operation: WIDTH+1 cycles.
  - div_by_zero and overflow: 1 cycle.
- Throughput: at most one result per WIDTH+2 cycles.
- in_valid while in_ready = 0 is ignored; no operands are lost or queued.
- rst_n asserted mid-operation (BUSY or DONE) aborts immediately. All outputs return to reset values; the in-flight result is discarded.
- Width rule: partial remainder is WIDTH+1 bits internally. Invariant: remainder < divisor at DONE for normal operations.

Optional Feature:
- Macro DIVIDER_11_STICKY_EN.
- When defined:
  - Adds output port sticky (out, 1) = |remainder, registered with the other results and valid with out_valid.
  - sticky = 1 for div_by_zero when dividend[WIDTH-1:0] != 0; sticky = 0 for overflow.
  - Used by FP rounding.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package divider_pkg holds:
  - DIV_WIDTH = 11.
  - Enum typedef div_state_t {IDLE, BUSY, DONE}.
  - Typedef div_rem_t, logic [DIV_WIDTH:0].
- One sub-module: divider_step. Combinational single restoring step taking partial remainder, incoming dividend bit and divisor; returning the next partial remainder and the quotient bit. Instantiated once in divider_11.

Test Plan:
- dividend=22'h200000, divisor=11'h7FF -> after 12 cycles quotient=11'h400, remainder=11'h400, flags 0.
- dividend=22'd1000, divisor=11'd7 -> quotient=11'd142, remainder=11'd6, out_valid exactly 12 cycles after accept.
- divisor=0, dividend=22'h000123 -> 1 cycle later div_by_zero=1, quotient=11'h7FF, remainder=11'h123, overflow=0.
- dividend=22'h3FFFFF, divisor=11'h400 -> 1 cycle later overflow=1, quotient=11'h7FF, remainder=0.
- Backpressure:
  - Result ready, out_ready low for 5 cycles -> outputs stable, in_ready=0 throughout.
  - A second in_valid during this window is not accepted.
  - Handshake then next op accepted.
- Reset mid-operation: rst_n pulled low in cycle 5 of BUSY -> out_valid=0 and outputs 0 immediately.
  - After release, in_ready=1 and a fresh 1000/7 returns 142/6.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative mantissa divider.
package divider_pkg;

    localparam int DIV_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Partial remainder: one bit wider than the divisor.
    typedef logic [DIV_WIDTH:0] div_rem_t;

endpackage : divider_pkg

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in the next dividend
// bit, try to subtract the divisor, keep the difference when it does not
// borrow. The subtraction is carried one bit wider than the partial
// remainder so the borrow out is the sign of the trial.
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   prem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   prem_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] trial_s;

    // Trial subtraction and restore selection.
    always_comb begin
        shifted_s = {prem, dvd_bit};
        trial_s   = shifted_s - {2'b00, divisor};
        q_bit     = ~trial_s[WIDTH+1];
        if (q_bit) begin
            prem_next = trial_s[WIDTH:0];
        end else begin
            prem_next = shifted_s[WIDTH:0];
        end
    end

endmodule : divider_step

// File: rtl/divider_11.sv
// Iterative radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per cycle, MSB first. Divide-by-zero and
// quotient overflow are detected at accept and answered in one cycle.
// Optional build macro DIVIDER_11_STICKY_EN adds the 'sticky' output
// (OR of the remainder bits) used by FP rounding.
module divider_11
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
`ifdef DIVIDER_11_STICKY_EN
    ,
    output logic               sticky
`endif
);

    localparam int CW = $clog2(WIDTH);

    div_state_t state_r;
    div_state_t next_state_s;

    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   prem_r;
    logic [WIDTH-1:0] dvd_lo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] quo_r;

    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_by_zero_r;
    logic             overflow_r;
    logic             out_valid_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             dbz_in_s;
    logic             ovf_in_s;
    logic             last_step_s;
    logic             dvd_bit_s;
    logic [WIDTH:0]   step_prem_s;
    logic             step_q_s;
    logic [WIDTH-1:0] quo_next_s;

    // Handshake and fast-path decode from current state and inputs.
    always_comb begin
        in_ready_s  = (state_r == IDLE);
        accept_s    = in_valid & in_ready_s;
        dbz_in_s    = (divisor == {WIDTH{1'b0}});
        ovf_in_s    = (dividend[2*WIDTH-1:WIDTH] >= divisor);
        last_step_s = (state_r == BUSY) && (cnt_r == {CW{1'b0}});
    end

    // The counter doubles as the index of the next low dividend bit and of
    // the quotient bit being produced, so no shift registers are needed.
    always_comb begin
        dvd_bit_s             = dvd_lo_r[cnt_r];
        quo_next_s            = quo_r;
        quo_next_s[cnt_r]     = step_q_s;
    end

    divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .prem      (prem_r),
        .dvd_bit   (dvd_bit_s),
        .divisor   (dvs_r),
        .prem_next (step_prem_s),
        .q_bit     (step_q_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (dbz_in_s || ovf_in_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = BUSY;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == {CW{1'b0}}) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = BUSY;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Working registers: operand capture on accept, one step per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CW{1'b0}};
            prem_r   <= {(WIDTH+1){1'b0}};
            dvd_lo_r <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            cnt_r    <= CW'(WIDTH-1);
            prem_r   <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
            dvd_lo_r <= dividend[WIDTH-1:0];
            dvs_r    <= divisor;
            quo_r    <= {WIDTH{1'b0}};
        end else if (state_r == BUSY) begin
            cnt_r    <= cnt_r - CW'(1);
            prem_r   <= step_prem_s;
            quo_r    <= quo_next_s;
        end else begin
            cnt_r    <= cnt_r;
            prem_r   <= prem_r;
            quo_r    <= quo_r;
        end
    end

    // Result registers: written on a fast-path accept or on the final step,
    // held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient_r    <= {WIDTH{1'b0}};
            remainder_r   <= {WIDTH{1'b0}};
            div_by_zero_r <= 1'b0;
            overflow_r    <= 1'b0;
            out_valid_r   <= 1'b0;
        end else if (accept_s && dbz_in_s) begin
            quotient_r    <= {WIDTH{1'b1}};
            remainder_r   <= dividend[WIDTH-1:0];
            div_by_zero_r <= 1'b1;
            overflow_r    <= 1'b0;
            out_valid_r   <= 1'b1;
        end else if (accept_s && ovf_in_s) begin
            quotient_r    <= {WIDTH{1'b1}};
            remainder_r   <= {WIDTH{1'b0}};
            div_by_zero_r <= 1'b0;
            overflow_r    <= 1'b1;
            out_valid_r   <= 1'b1;
        end else if (last_step_s) begin
            quotient_r    <= quo_next_s;
            remainder_r   <= step_prem_s[WIDTH-1:0];
            div_by_zero_r <= 1'b0;
            overflow_r    <= 1'b0;
            out_valid_r   <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r   <= 1'b0;
        end else begin
            out_valid_r   <= out_valid_r;
        end
    end

`ifdef DIVIDER_11_STICKY_EN
    logic sticky_r;

    // Sticky bit tracks the remainder written alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
        end else if (accept_s && dbz_in_s) begin
            sticky_r <= |dividend[WIDTH-1:0];
        end else if (accept_s && ovf_in_s) begin
            sticky_r <= 1'b0;
        end else if (last_step_s) begin
            sticky_r <= |step_prem_s[WIDTH-1:0];
        end else begin
            sticky_r <= sticky_r;
        end
    end

    assign sticky = sticky_r;
`endif

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = div_by_zero_r;
    assign overflow    = overflow_r;

endmodule : divider_11

// File: tb/tb_divider_11.sv
// Directed bench for divider_11: hand-computed vectors, latency,
// backpressure and mid-operation reset.
module tb_divider_11;
    import divider_pkg::*;

    localparam int W = DIV_WIDTH;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;
`ifdef DIVIDER_11_STICKY_EN
    logic           sticky;
`endif

    int n_vec = 0;
    int n_err = 0;

    divider_11 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
`ifdef DIVIDER_11_STICKY_EN
        ,
        .sticky      (sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand pair for exactly one accepting edge.
    task automatic launch(input string tag, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen (accept edge = 1).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input logic eov, input int elat);
        int lat;
        launch(tag, dvd, dvs);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"},   32'(quotient), 32'(eq));
        check({tag, "_r"},   32'(remainder), 32'(er));
        check({tag, "_dz"},  32'(div_by_zero), 32'(edz));
        check({tag, "_ov"},  32'(overflow), 32'(eov));
`ifdef DIVIDER_11_STICKY_EN
        if (edz) begin
            check({tag, "_st"}, 32'(sticky), 32'(|dvd[W-1:0]));
        end else if (eov) begin
            check({tag, "_st"}, 32'(sticky), 32'd0);
        end else begin
            check({tag, "_st"}, 32'(sticky), 32'(er != '0));
        end
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q",         32'(quotient), 32'd0);
        check("rst_r",         32'(remainder), 32'd0);
        check("rst_dz",        32'(div_by_zero), 32'd0);
        check("rst_ov",        32'(overflow), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);

        run_op("half",   22'h200000, 11'h7FF, 11'h400, 11'h400, 1'b0, 1'b0, 12);
        run_op("d1000",  22'd1000,   11'd7,   11'd142, 11'd6,   1'b0, 1'b0, 12);
        run_op("dz",     22'h000123, 11'h000, 11'h7FF, 11'h123, 1'b1, 1'b0, 1);
        run_op("ovf",    22'h3FFFFF, 11'h400, 11'h7FF, 11'h000, 1'b0, 1'b1, 1);
        run_op("maxq",   22'h1FFFFF, 11'h400, 11'h7FF, 11'h3FF, 1'b0, 1'b0, 12);
        run_op("div1",   22'h0007FF, 11'h001, 11'h7FF, 11'h000, 1'b0, 1'b0, 12);
        run_op("ovfeq",  22'h002800, 11'd5,   11'h7FF, 11'h000, 1'b0, 1'b1, 1);
        run_op("dz0",    22'h3FF800, 11'h000, 11'h7FF, 11'h000, 1'b1, 1'b0, 1);
        run_op("zero",   22'h000000, 11'd5,   11'h000, 11'h000, 1'b0, 1'b0, 12);
        run_op("small",  22'd100,    11'd200, 11'h000, 11'd100, 1'b0, 1'b0, 12);

        // Backpressure: hold the result while a competing request is offered.
        launch("bp", 22'd1000, 11'd7);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd12);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 22'h3FFFFF;
            divisor  = 11'h000;
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_q",     32'(quotient), 32'd142);
            check("bp_r",     32'(remainder), 32'd6);
            check("bp_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_drop",  32'(out_valid), 32'd0);
        check("bp_idle",  32'(in_ready), 32'd1);
        check("bp_nodz",  32'(div_by_zero), 32'd0);
        run_op("bp_next", 22'h200000, 11'h7FF, 11'h400, 11'h400, 1'b0, 1'b0, 12);

        // Reset during the fifth BUSY cycle discards the operation.
        launch("rst", 22'd1000, 11'd7);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_q",     32'(quotient), 32'd0);
        check("mid_rst_r",     32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        run_op("after_rst", 22'd1000, 11'd7, 11'd142, 11'd6, 1'b0, 1'b0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_divider_11
